mp_display_controller: RTL

//   Display-side consumer of the timer controller outputs (cur_phase, seven_num, set).

---
 rtl/mp_disp_pkg.sv | 40 ++++
 rtl/mp_seg7_decoder.sv | 19 +
 rtl/mp_display_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mp_disp_pkg.sv
// Shared constants for the display controller: segment patterns, slot
// numbering and the active-low 7-segment digit table ({g,f,e,d,c,b,a}).
package mp_disp_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_P     = 7'b0001100;

   localparam logic [2:0] PHASE_MAX = 3'd4;

   // Value fed to the decoder when a field is out of range; the table maps it to a dash
   localparam logic [3:0] VALUE_DASH = 4'hF;

   typedef enum logic [1:0] {
      SLOT_NUM   = 2'd0,
      SLOT_BLANK = 2'd1,
      SLOT_PHASE = 2'd2,
      SLOT_P     = 2'd3
   } slot_t;

   // Entries 10..15 are not BCD digits and render as a dash
   localparam logic [15:0][6:0] DIGIT_TABLE = {
      SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   function automatic logic [3:0] slot_anode(input slot_t s);
      return ~(4'b0001 << s);
   endfunction

endpackage

// File: rtl/mp_seg7_decoder.sv
// Combinational digit decoder: 4-bit value plus blank request to an
// active-low segment pattern. Values above 9 render as a dash.
module mp_seg7_decoder
   import mp_disp_pkg::*;
(
   input  logic [3:0] value,
   input  logic       blank,
   output logic [6:0] seg
);

   // Blank wins over the value; otherwise look the value up in the digit table
   always_comb begin
      seg = DIGIT_TABLE[value];
      if (blank) begin
         seg = SEG_BLANK;
      end
   end

endmodule

// File: rtl/mp_display_controller.sv
// Display-side consumer of the timer outputs. Scans a 4-digit common-anode
// 7-segment display (seconds digit, blank, phase digit, 'P'), drives one-hot
// phase LEDs and samples its inputs once per scan frame so digits never
// change mid-frame. Set mode lights the decimal point on the seconds digit.
// Optional feature: define MP_DISP_BLINK_EN to also blink the editable
// digits (slots 0 and 2) while in set mode.
module mp_display_controller
   import mp_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 25000,
   parameter int BLINK_DIV   = 6250000
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       set,
   input  logic [2:0] cur_phase,
   input  logic [3:0] seven_num,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic [4:0] led
);

   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

   logic [REF_W-1:0] ref_cnt;
   slot_t            scan_idx;
   logic [3:0]       num_s;
   logic [2:0]       phase_s;
   logic             set_s;
   logic             blink_vis;
   logic             slot_end;
   logic             frame_end;
   logic [3:0]       dec_value;
   logic             dec_blank;
   logic [6:0]       dec_seg;

   assign slot_end  = (ref_cnt == REF_LAST);
   assign frame_end = slot_end && (scan_idx == SLOT_P);

   // Slot timer: advance to the next digit every REFRESH_DIV clocks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt  <= '0;
         scan_idx <= SLOT_NUM;
      end else if (slot_end) begin
         ref_cnt  <= '0;
         scan_idx <= slot_t'(scan_idx + 2'd1);
      end else begin
         ref_cnt <= ref_cnt + REF_W'(1);
      end
   end

   // Capture the displayed values only at the end of the last slot of a frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_s   <= '0;
         phase_s <= '0;
         set_s   <= 1'b0;
      end else if (frame_end) begin
         num_s   <= seven_num;
         phase_s <= cur_phase;
         set_s   <= set;
      end
   end

`ifdef MP_DISP_BLINK_EN
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [BLINK_W-1:0] blink_cnt;
   logic               edit_restart;

   // An edit captured in set mode restarts the blink so the new value is seen at once
   assign edit_restart = frame_end && set &&
                         ((seven_num != num_s) || (cur_phase != phase_s));

   // Blink phase generator for the editable digits; idle and visible outside set mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_vis <= 1'b1;
      end else if (edit_restart || !set_s) begin
         blink_cnt <= '0;
         blink_vis <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         blink_vis <= ~blink_vis;
      end else begin
         blink_cnt <= blink_cnt + BLINK_W'(1);
      end
   end
`else
   assign blink_vis = 1'b1;
`endif

   // Slot mux: choose what the single decoder renders for the current slot
   always_comb begin
      dec_value = num_s;
      dec_blank = 1'b1;
      case (scan_idx)
         SLOT_NUM: begin
            dec_value = num_s;
            dec_blank = ~blink_vis;
         end
         SLOT_PHASE: begin
            dec_value = (phase_s > PHASE_MAX) ? VALUE_DASH : {1'b0, phase_s};
            dec_blank = ~blink_vis;
         end
         default: begin
            dec_blank = 1'b1;
         end
      endcase
   end

   mp_seg7_decoder u_decoder (
      .value (dec_value),
      .blank (dec_blank),
      .seg   (dec_seg)
   );

   // Register anode, segments and decimal point together so they switch on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= 4'b1111;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= slot_anode(scan_idx);
         seg <= (scan_idx == SLOT_P) ? SEG_P : dec_seg;
         dp  <= ~((scan_idx == SLOT_NUM) && set_s);
      end
   end

   // Phase LEDs follow the live phase input, dark for out-of-range phases
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led <= '0;
      end else if (cur_phase <= PHASE_MAX) begin
         led <= 5'(5'b00001 << cur_phase);
      end else begin
         led <= '0;
      end
   end

endmodule
